// File: rtl/ldst_request_buffer.sv
// rtl/ldst_request_buffer.sv - in-order load/store request queue with response alignment
//
// Purpose:
//   Holds up to DEPTH load/store requests (queued plus in flight) between the
//   load/store pipe arbiter and the MMU/data-cache port. Requests are forwarded
//   in order; each memory response is matched with the oldest outstanding tag
//   and returned to the arbiter with read data right-aligned by access order.
//
// Ports:
//   iCLOCK, inRESET (async, active-low), iRESET_SYNC (sync flush, active-high)
//   Upstream  : iLDST_REQ / oLDST_BUSY handshake, iLDST_* request fields,
//               oLDST_VALID / oLDST_MMU_FLAGS / oLDST_DATA response
//   Downstream: oMEM_REQ / iMEM_BUSY handshake, oMEM_* head-entry fields,
//               iMEM_VALID / iMEM_MMU_FLAGS / iMEM_DATA response
module ldst_request_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iLDST_REQ,
  output logic        oLDST_BUSY,
  input  logic [1:0]  iLDST_ORDER,
  input  logic [3:0]  iLDST_MASK,
  input  logic        iLDST_RW,
  input  logic [13:0] iLDST_ASID,
  input  logic [1:0]  iLDST_MMUMOD,
  input  logic [2:0]  iLDST_MMUPS,
  input  logic [31:0] iLDST_PDT,
  input  logic [31:0] iLDST_ADDR,
  input  logic [31:0] iLDST_DATA,
  output logic        oLDST_VALID,
  output logic [11:0] oLDST_MMU_FLAGS,
  output logic [31:0] oLDST_DATA,
  output logic        oMEM_REQ,
  input  logic        iMEM_BUSY,
  output logic [1:0]  oMEM_ORDER,
  output logic [3:0]  oMEM_MASK,
  output logic        oMEM_RW,
  output logic [13:0] oMEM_ASID,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [2:0]  oMEM_MMUPS,
  output logic [31:0] oMEM_PDT,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic [11:0] iMEM_MMU_FLAGS,
  input  logic [31:0] iMEM_DATA
);

  localparam int             CMD_W     = 122;
  localparam int             TAG_W     = 5;
  localparam logic [PTR_W:0] L_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] L_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] L_PTR_ONE = PTR_W'(1);

  logic [CMD_W-1:0] r_cmd_mem [DEPTH];
  logic [TAG_W-1:0] r_tag_mem [DEPTH];

  // Both FIFOs push on the same accept, so they share one write pointer.
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_cmd_rptr;
  logic [PTR_W-1:0] r_tag_rptr;
  logic [PTR_W:0]   r_cmd_cnt;
  logic [PTR_W:0]   r_cnt;

  logic        r_valid;
  logic [11:0] r_flags;
  logic [31:0] r_data;

  logic             w_busy;
  logic             w_accept;
  logic             w_mem_req;
  logic             w_issue;
  logic             w_resp;
  logic [CMD_W-1:0] w_cmd_in;
  logic [CMD_W-1:0] w_head;
  logic [TAG_W-1:0] w_tag;
  logic             w_tag_rw;
  logic [1:0]       w_tag_order;
  logic [1:0]       w_tag_addr;
  logic [31:0]      w_rdata;

  // Busy comes only from the registered count, so an accept never depends on a
  // response arriving in the same cycle.
  assign w_busy    = (r_cnt == L_FULL);
  assign w_accept  = iLDST_REQ && !w_busy;
  assign w_mem_req = (r_cmd_cnt != '0);
  assign w_issue   = w_mem_req && !iMEM_BUSY;
  // A response with nothing outstanding is dropped.
  assign w_resp    = iMEM_VALID && (r_cnt != '0);

  assign w_cmd_in = {iLDST_ORDER, iLDST_MASK, iLDST_RW, iLDST_ASID, iLDST_MMUMOD,
                     iLDST_MMUPS, iLDST_PDT, iLDST_ADDR, iLDST_DATA};

  // Stale storage is masked so the memory-side fields read 0 when empty.
  assign w_head = w_mem_req ? r_cmd_mem[r_cmd_rptr] : '0;

  assign {oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_ASID, oMEM_MMUMOD,
          oMEM_MMUPS, oMEM_PDT, oMEM_ADDR, oMEM_DATA} = w_head;

  assign oMEM_REQ        = w_mem_req;
  assign oLDST_BUSY      = w_busy;
  assign oLDST_VALID     = r_valid;
  assign oLDST_MMU_FLAGS = r_flags;
  assign oLDST_DATA      = r_data;

  assign w_tag       = r_tag_mem[r_tag_rptr];
  assign w_tag_rw    = w_tag[4];
  assign w_tag_order = w_tag[3:2];
  assign w_tag_addr  = w_tag[1:0];

  // Big-endian lanes: lane 0 is [31:24].
  always_comb begin
    w_rdata = iMEM_DATA;
    if (w_tag_rw) begin
      w_rdata = 32'h0;
    end else if (w_tag_order == 2'b00) begin
      case (w_tag_addr)
        2'd0:    w_rdata = {24'h0, iMEM_DATA[31:24]};
        2'd1:    w_rdata = {24'h0, iMEM_DATA[23:16]};
        2'd2:    w_rdata = {24'h0, iMEM_DATA[15:8]};
        default: w_rdata = {24'h0, iMEM_DATA[7:0]};
      endcase
    end else if (w_tag_order == 2'b01) begin
      w_rdata = w_tag_addr[1] ? {16'h0, iMEM_DATA[15:0]} : {16'h0, iMEM_DATA[31:16]};
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (w_accept && !iRESET_SYNC) begin
      r_cmd_mem[r_wptr] <= w_cmd_in;
      r_tag_mem[r_wptr] <= {iLDST_RW, iLDST_ORDER, iLDST_ADDR[1:0]};
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wptr     <= '0;
      r_cmd_rptr <= '0;
      r_tag_rptr <= '0;
      r_cmd_cnt  <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_flags    <= '0;
      r_data     <= '0;
    end else if (iRESET_SYNC) begin
      r_wptr     <= '0;
      r_cmd_rptr <= '0;
      r_tag_rptr <= '0;
      r_cmd_cnt  <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_flags    <= '0;
      r_data     <= '0;
    end else begin
      if (w_accept) r_wptr     <= r_wptr + L_PTR_ONE;
      if (w_issue)  r_cmd_rptr <= r_cmd_rptr + L_PTR_ONE;
      if (w_resp)   r_tag_rptr <= r_tag_rptr + L_PTR_ONE;

      case ({w_accept, w_issue})
        2'b10:   r_cmd_cnt <= r_cmd_cnt + L_CNT_ONE;
        2'b01:   r_cmd_cnt <= r_cmd_cnt - L_CNT_ONE;
        default: r_cmd_cnt <= r_cmd_cnt;
      endcase

      case ({w_accept, w_resp})
        2'b10:   r_cnt <= r_cnt + L_CNT_ONE;
        2'b01:   r_cnt <= r_cnt - L_CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase

      r_valid <= w_resp;
      if (w_resp) begin
        r_data  <= w_rdata;
        r_flags <= iMEM_MMU_FLAGS;
      end
    end
  end

endmodule
